cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Sequencing FSM between a requester, the direct-mapped Cache and DataMemory.
//  Accepts one 15-bit word-address read at a time and issues a cache lookup.
//  On hit: returns the selected 32-bit word. On miss: fetches the 128-bit line
//  from memory, writes it into the cache, then returns the word.
//  Keeps saturating hit/miss statistics counters.
// PARAMETERS
//  ADDR_W   15   word address width; addr[1:0] selects word within line
//  LINE_W   128  line width (4 x 32-bit words)
//  CNT_W    16   width of hit_count / miss_count
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  req_valid      in   1       read request
//  req_addr       in   ADDR_W  word address; captured when req_valid & req_ready
//  req_ready      out  1       high only in IDLE
//  resp_valid     out  1       read data valid; held until resp_ready
//  resp_ready     in   1       requester accepts resp_data
//  resp_data      out  32      selected word
//  cache_lookup   out  1       one-cycle lookup strobe to cache, uses cache_addr
//  cache_addr     out  ADDR_W  captured request address (stable IDLE exit -> RESP exit)
//  cache_hit      in   1       valid in cycle after cache_lookup
//  cache_rd_line  in   LINE_W  hit line, valid with cache_hit
//  cache_wr_en    out  1       one-cycle line write strobe
//  cache_wr_line  out  LINE_W  line to write (the fetched memory line)
//  mem_rd_req     out  1       line fetch request, level, held until mem_rd_valid
//  mem_rd_valid   in   1       memory line ready (latency >= 0 cycles)
//  mem_rd_line    in   LINE_W  fetched line, valid with mem_rd_valid
//  hit_count      out  CNT_W   saturating hit counter
//  miss_count     out  CNT_W   saturating miss counter
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, req_ready=1, all other outputs 0,
//   line/addr registers 0, counters 0; pending memory request abandoned.
//  States: IDLE -> LOOKUP -> (hit) RESP | (miss) MEM_WAIT -> FILL -> RESP -> IDLE.
//  IDLE: req_valid=1 -> capture addr, assert cache_lookup next cycle; go LOOKUP.
//  LOOKUP: sample cache_hit. Hit: latch cache_rd_line, hit_count++, go RESP.
//   Miss: miss_count++, assert mem_rd_req, go MEM_WAIT.
//  MEM_WAIT: mem_rd_req held high; on mem_rd_valid latch mem_rd_line,
//   drop mem_rd_req next cycle, go FILL. No timeout; waits indefinitely.
//  FILL: cache_wr_en=1 for exactly one cycle with latched line; go RESP.
//  RESP: resp_valid=1; resp_data = line word by addr[1:0]:
//   00->[31:0], 01->[63:32], 10->[95:64], 11->[127:96].
//   resp_valid & resp_ready -> IDLE; data stable while stalled.
//  Latency (req handshake to resp_valid): hit = 2 cycles;
//   miss = 3 + memory latency + 1 (FILL) cycles.
//  req_valid while not IDLE: ignored (req_ready=0); no queueing.
//  Back-to-back: next request accepted in the cycle after the RESP handshake.
//  Counters saturate at all-ones; no wrap.
//  Outputs are registered; no combinational path req_valid->req_ready or
//   mem_rd_valid->cache_wr_en.
// STRUCTURE
//  Package cache_pkg: ADDR_W/LINE_W/WORD_W constants, state enum
//   (IDLE, LOOKUP, MEM_WAIT, FILL, RESP), word_select function.
//  Sub-module sat_counter (CNT_W, inc, count) instantiated twice; FSM and
//   datapath registers live in cache_refill_ctrl.
// TESTING
//  1 Reset mid-MEM_WAIT: rst pulse -> mem_rd_req=0, req_ready=1, counters=0 same cycle.
//  2 Hit: addr=15'h0012, cache_hit=1, line word2=32'hCAFEBABE -> resp_valid 2 cycles
//    after accept, resp_data=32'hCAFEBABE, hit_count=1, no mem_rd_req.
//  3 Miss, mem latency 5: addr=15'h0103 -> mem_rd_req high 6 cycles,
//    one cache_wr_en with fetched line, resp_data=line[127:96], miss_count=1.
//  4 Miss with mem_rd_valid same cycle as mem_rd_req -> FILL next cycle, correct data.
//  5 resp_ready low 4 cycles -> resp_valid/resp_data stable; req_valid pulses ignored.
//  6 Saturation (CNT_W=4): 17 hits -> hit_count=4'hF, no wrap.

Source files
------------

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Shared constants, FSM state encoding and the line-to-word selector used by
//   cache_refill_ctrl.
//   ADDR_W : word address width (addr[1:0] selects the word within a line)
//   LINE_W : cache line width (four words)
//   WORD_W : returned word width
//   CNT_W  : default statistics counter width
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int unsigned ADDR_W = 15;
   localparam int unsigned LINE_W = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MEM_WAIT,
      FILL,
      RESP
   } state_e;

   // Picks word sel out of a four-word line; word 0 lives in the low bits.
   function automatic logic [WORD_W-1:0] word_select(
      input logic [LINE_W-1:0] line,
      input logic [1:0]        sel
   );
      logic [WORD_W-1:0] w;
      w = '0;
      case (sel)
         2'd0: w = line[0*WORD_W +: WORD_W];
         2'd1: w = line[1*WORD_W +: WORD_W];
         2'd2: w = line[2*WORD_W +: WORD_W];
         2'd3: w = line[3*WORD_W +: WORD_W];
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (count -> 0)
//   i_inc   : increment request for this cycle
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Sequences one read at a time between a requester, a direct-mapped cache
//   and a line-wide data memory. Hits return the word straight from the
//   looked-up line; misses fetch the line, write it into the cache, then
//   return the word. Hit and miss totals are kept in saturating counters.
//
//   clk, rst        : clock / asynchronous active-high reset
//   req_valid/ready : request handshake, req_addr captured on accept
//   resp_valid/ready: response handshake, resp_data held while stalled
//   cache_lookup    : one-cycle lookup strobe, cache_addr = captured address
//   cache_hit/rd_line: lookup result, valid the cycle after the strobe
//   cache_wr_en/line: one-cycle refill write of the fetched line
//   mem_rd_req      : level fetch request, held until mem_rd_valid
//   mem_rd_valid/line: fetched line
//   hit_count/miss_count: saturating statistics
// -----------------------------------------------------------------------------
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = cache_pkg::ADDR_W,
   parameter int unsigned LINE_W = cache_pkg::LINE_W,
   parameter int unsigned CNT_W  = cache_pkg::CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   input  logic [ADDR_W-1:0]         req_addr,
   output logic                      req_ready,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [cache_pkg::WORD_W-1:0] resp_data,
   output logic                      cache_lookup,
   output logic [ADDR_W-1:0]         cache_addr,
   input  logic                      cache_hit,
   input  logic [LINE_W-1:0]         cache_rd_line,
   output logic                      cache_wr_en,
   output logic [LINE_W-1:0]         cache_wr_line,
   output logic                      mem_rd_req,
   input  logic                      mem_rd_valid,
   input  logic [LINE_W-1:0]         mem_rd_line,
   output logic [CNT_W-1:0]          hit_count,
   output logic [CNT_W-1:0]          miss_count
);

   state_e              r_state;
   state_e              w_state_nxt;

   // LOOKUP spans two cycles: the strobe cycle, then the cycle in which the
   // cache answers. r_lk_sample marks the second one.
   logic                r_lk_sample;

   logic [ADDR_W-1:0]   r_addr;
   logic [LINE_W-1:0]   r_line;

   logic                r_req_ready;
   logic                r_resp_valid;
   logic                r_cache_lookup;
   logic                r_cache_wr_en;
   logic                r_mem_rd_req;

   logic                w_req_ready_nxt;
   logic                w_resp_valid_nxt;
   logic                w_cache_lookup_nxt;
   logic                w_cache_wr_en_nxt;
   logic                w_mem_rd_req_nxt;

   logic                w_accept;
   logic                w_hit_evt;
   logic                w_miss_evt;
   logic                w_mem_done;

   assign w_accept   = (r_state == IDLE) && req_valid;
   assign w_hit_evt  = (r_state == LOOKUP) && r_lk_sample && cache_hit;
   assign w_miss_evt = (r_state == LOOKUP) && r_lk_sample && !cache_hit;
   assign w_mem_done = (r_state == MEM_WAIT) && mem_rd_valid;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_lk_sample <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lk_sample <= (r_state == LOOKUP) && !r_lk_sample;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (req_valid)    w_state_nxt = LOOKUP;
         LOOKUP:   if (r_lk_sample)  w_state_nxt = cache_hit ? RESP : MEM_WAIT;
         MEM_WAIT: if (mem_rd_valid) w_state_nxt = FILL;
         FILL:                       w_state_nxt = RESP;
         RESP:     if (resp_ready)   w_state_nxt = IDLE;
         default:                    w_state_nxt = IDLE;
      endcase
   end

   // Output logic: every control output is a flop loaded from the upcoming
   // state, so none of them sees a combinational path from an input.
   always_comb begin
      w_req_ready_nxt    = (w_state_nxt == IDLE);
      w_resp_valid_nxt   = (w_state_nxt == RESP);
      w_cache_lookup_nxt = (r_state == IDLE) && (w_state_nxt == LOOKUP);
      w_cache_wr_en_nxt  = (w_state_nxt == FILL);
      w_mem_rd_req_nxt   = (w_state_nxt == MEM_WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req_ready    <= 1'b1;
         r_resp_valid   <= 1'b0;
         r_cache_lookup <= 1'b0;
         r_cache_wr_en  <= 1'b0;
         r_mem_rd_req   <= 1'b0;
      end else begin
         r_req_ready    <= w_req_ready_nxt;
         r_resp_valid   <= w_resp_valid_nxt;
         r_cache_lookup <= w_cache_lookup_nxt;
         r_cache_wr_en  <= w_cache_wr_en_nxt;
         r_mem_rd_req   <= w_mem_rd_req_nxt;
      end
   end

   // Datapath: captured address and the line being returned/written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= req_addr;
         end
         if (w_hit_evt) begin
            r_line <= cache_rd_line;
         end else if (w_mem_done) begin
            r_line <= mem_rd_line;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_hit_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_hit_evt),
      .o_count (hit_count)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_miss_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_miss_evt),
      .o_count (miss_count)
   );

   assign req_ready     = r_req_ready;
   assign resp_valid    = r_resp_valid;
   assign cache_lookup  = r_cache_lookup;
   assign cache_wr_en   = r_cache_wr_en;
   assign mem_rd_req    = r_mem_rd_req;
   assign cache_addr    = r_addr;
   assign cache_wr_line = r_line;
   // Line and address are both frozen from RESP entry until the handshake.
   assign resp_data     = word_select(r_line, r_addr[1:0]);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic [14:0]   req_addr;
   logic          resp_ready;
   logic          cache_hit;
   logic [127:0]  cache_rd_line;
   logic          mem_rd_valid;
   logic [127:0]  mem_rd_line;

   logic          req_ready, resp_valid, cache_lookup, cache_wr_en, mem_rd_req;
   logic [31:0]   resp_data;
   logic [14:0]   cache_addr;
   logic [127:0]  cache_wr_line;
   logic [15:0]   hit_count, miss_count;

   logic          u4_req_ready, u4_resp_valid, u4_cache_lookup, u4_cache_wr_en, u4_mem_rd_req;
   logic [31:0]   u4_resp_data;
   logic [14:0]   u4_cache_addr;
   logic [127:0]  u4_cache_wr_line;
   logic [3:0]    u4_hit_count, u4_miss_count;

   cache_refill_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .cache_lookup(cache_lookup), .cache_addr(cache_addr),
      .cache_hit(cache_hit), .cache_rd_line(cache_rd_line),
      .cache_wr_en(cache_wr_en), .cache_wr_line(cache_wr_line),
      .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rd_line(mem_rd_line),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // Narrow-counter instance sharing the same stimulus, for saturation.
   cache_refill_ctrl #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(u4_req_ready),
      .resp_valid(u4_resp_valid), .resp_ready(resp_ready), .resp_data(u4_resp_data),
      .cache_lookup(u4_cache_lookup), .cache_addr(u4_cache_addr),
      .cache_hit(cache_hit), .cache_rd_line(cache_rd_line),
      .cache_wr_en(u4_cache_wr_en), .cache_wr_line(u4_cache_wr_line),
      .mem_rd_req(u4_mem_rd_req), .mem_rd_valid(mem_rd_valid), .mem_rd_line(mem_rd_line),
      .hit_count(u4_hit_count), .miss_count(u4_miss_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int unsigned exp_hits = 0;
   int unsigned exp_miss = 0;

   typedef struct {
      logic [14:0]  addr;
      logic         hit;
      logic [127:0] line;
      int unsigned  lat;
      int unsigned  stall;
      logic [31:0]  exp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned sat4(input int unsigned v);
      return (v > 15) ? 15 : v;
   endfunction

   // Runs one full transaction starting at a negedge with the DUT idle.
   task automatic run_txn(input logic [14:0] addr, input logic hit, input logic [127:0] line,
                          input int unsigned lat, input int unsigned stall, input logic [31:0] exp);
      int unsigned acc, reqc, wrc, t;
      chk("req_ready_idle", 128'(req_ready), 128'(1));
      req_valid = 1'b1;
      req_addr  = addr;
      @(negedge clk);
      acc = cyc;
      req_valid = 1'b0;
      req_addr  = ~addr;
      chk("lookup_strobe", 128'(cache_lookup), 128'(1));
      chk("cache_addr", 128'(cache_addr), 128'(addr));
      chk("req_ready_busy", 128'(req_ready), 128'(0));
      // Wrong answer during the strobe cycle; the real one comes a cycle later.
      cache_hit     = ~hit;
      cache_rd_line = ~line;
      @(negedge clk);
      chk("lookup_one_cycle", 128'(cache_lookup), 128'(0));
      cache_hit     = hit;
      cache_rd_line = line;
      @(negedge clk);
      cache_hit     = 1'b0;
      cache_rd_line = '0;
      reqc = 0;
      wrc  = 0;
      t    = 0;
      while (!resp_valid && t < 60) begin
         if (cache_wr_en) begin
            wrc++;
            chk("wr_line", cache_wr_line, line);
         end
         if (mem_rd_req) begin
            if (reqc == lat) begin
               mem_rd_valid = 1'b1;
               mem_rd_line  = line;
            end else begin
               mem_rd_valid = 1'b0;
               mem_rd_line  = ~line;
            end
            reqc++;
         end else begin
            mem_rd_valid = 1'b0;
            mem_rd_line  = '0;
         end
         @(negedge clk);
         t++;
      end
      mem_rd_valid = 1'b0;
      mem_rd_line  = '0;
      if (hit) exp_hits++; else exp_miss++;
      chk("latency", 128'(cyc - acc), 128'(hit ? 2 : lat + 4));
      chk("mem_req_cycles", 128'(reqc), 128'(hit ? 0 : lat + 1));
      chk("wr_en_cycles", 128'(wrc), 128'(hit ? 0 : 1));
      chk("mem_req_low_resp", 128'(mem_rd_req), 128'(0));
      chk("hit_count", 128'(hit_count), 128'(exp_hits));
      chk("miss_count", 128'(miss_count), 128'(exp_miss));
      chk("hit_count_w4", 128'(u4_hit_count), 128'(sat4(exp_hits)));
      chk("miss_count_w4", 128'(u4_miss_count), 128'(sat4(exp_miss)));
      for (int s = 0; s < int'(stall); s++) begin
         resp_ready = 1'b0;
         req_valid  = 1'b1;
         req_addr   = addr ^ 15'h0001;
         chk("stall_valid", 128'(resp_valid), 128'(1));
         chk("stall_data", 128'(resp_data), 128'(exp));
         chk("stall_req_ready", 128'(req_ready), 128'(0));
         chk("stall_addr", 128'(cache_addr), 128'(addr));
         @(negedge clk);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      chk("resp_valid", 128'(resp_valid), 128'(1));
      chk("resp_data", 128'(resp_data), 128'(exp));
      @(negedge clk);
      resp_ready = 1'b0;
      chk("resp_done", 128'(resp_valid), 128'(0));
      chk("req_ready_after", 128'(req_ready), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{addr: 15'h0012, hit: 1'b1, line: 128'h44444444_CAFEBABE_22222222_11111111,
                  lat: 0, stall: 0, exp: 32'hCAFEBABE};
      vecs[1] = '{addr: 15'h0103, hit: 1'b0, line: 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C,
                  lat: 5, stall: 0, exp: 32'hDEADBEEF};
      vecs[2] = '{addr: 15'h0200, hit: 1'b0, line: 128'hA5A5A5A5_5A5A5A5A_FFFF0000_12345678,
                  lat: 0, stall: 0, exp: 32'h12345678};
      vecs[3] = '{addr: 15'h7FFD, hit: 1'b1, line: 128'h0BAD0001_0BAD0002_0BAD0003_0BAD0004,
                  lat: 0, stall: 4, exp: 32'h0BAD0003};
      vecs[4] = '{addr: 15'h4ABE, hit: 1'b0, line: 128'h00000001_00000002_00000003_00000004,
                  lat: 2, stall: 1, exp: 32'h00000002};

      rst           = 1'b1;
      req_valid     = 1'b0;
      req_addr      = '0;
      resp_ready    = 1'b0;
      cache_hit     = 1'b0;
      cache_rd_line = '0;
      mem_rd_valid  = 1'b0;
      mem_rd_line   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_req_ready", 128'(req_ready), 128'(1));
      chk("rst_resp_valid", 128'(resp_valid), 128'(0));
      chk("rst_lookup", 128'(cache_lookup), 128'(0));
      chk("rst_mem_req", 128'(mem_rd_req), 128'(0));
      chk("rst_wr_en", 128'(cache_wr_en), 128'(0));
      chk("rst_resp_data", 128'(resp_data), 128'(0));
      chk("rst_cache_addr", 128'(cache_addr), 128'(0));
      chk("rst_hit_count", 128'(hit_count), 128'(0));
      chk("rst_miss_count", 128'(miss_count), 128'(0));

      // Reset asserted asynchronously while a miss waits on memory.
      req_valid = 1'b1;
      req_addr  = 15'h0055;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_mem_req", 128'(mem_rd_req), 128'(1));
      chk("pre_rst_miss_count", 128'(miss_count), 128'(1));
      @(negedge clk);
      chk("pre_rst_mem_req_held", 128'(mem_rd_req), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_mem_req", 128'(mem_rd_req), 128'(0));
      chk("arst_req_ready", 128'(req_ready), 128'(1));
      chk("arst_miss_count", 128'(miss_count), 128'(0));
      chk("arst_miss_count_w4", 128'(u4_miss_count), 128'(0));
      chk("arst_cache_addr", 128'(cache_addr), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i].addr, vecs[i].hit, vecs[i].line, vecs[i].lat, vecs[i].stall, vecs[i].exp);
      end

      // 17 back-to-back hits: the 4-bit counter must stop at 4'hF.
      for (int i = 0; i < 17; i++) begin
         logic [31:0] w;
         w = 32'hF00D0000 | 32'(i);
         run_txn(15'h0100 + 15'(i), 1'b1, {4{w}}, 0, 0, w);
      end

      chk("final_hit_count", 128'(hit_count), 128'(16'd19));
      chk("final_miss_count", 128'(miss_count), 128'(16'd3));
      chk("sat_hit_count_w4", 128'(u4_hit_count), 128'(4'hF));
      chk("final_miss_count_w4", 128'(u4_miss_count), 128'(4'd3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
